// File: rtl/nexys_starship_repair_bank_pkg.sv
// Shared definitions for the Nexys Starship section modules: one-hot
// channel state encoding reused by every repairable section.
package nexys_starship_repair_bank_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT    = 3'b001,
    ST_WORKING = 3'b010,
    ST_REPAIR  = 3'b100
  } ch_state_e;

endpackage

// File: rtl/nexys_starship_repair_ch.sv
// One repairable ship section: one-hot FSM, latched combo, digit index,
// fail counter, repair timer and lock flag.
module nexys_starship_repair_ch
  import nexys_starship_repair_bank_pkg::*;
#(
  parameter int COMBO_DIGITS   = 2,
  parameter int MAX_FAILS      = 3,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      play_flag,
  input  logic                      gameover_ctrl,
  input  logic                      break_req,
  input  logic [4*COMBO_DIGITS-1:0] random_hex,
  input  logic [3:0]                hex_combo,
  input  logic                      btn_submit,
  output logic                      q_init,
  output logic                      q_working,
  output logic                      q_repair,
  output logic                      broken,
  output logic [4*COMBO_DIGITS-1:0] combo,
  output logic [1:0]                digit_idx,
  output logic [3:0]                fail_cnt,
  output logic                      repaired,
  output logic                      loss_ev
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = 4 * COMBO_DIGITS;

  ch_state_e       state_q, state_d;
  logic [CW-1:0]   combo_q, combo_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            locked_q, locked_d;
  logic            repaired_q, repaired_d;
  logic [3:0]      cur_digit;
  logic            timeout_hit;
  logic            fail_limit;

  assign cur_digit   = 4'(combo_q >> {idx_q, 2'b00});
  assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    combo_d    = combo_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    locked_d   = locked_q;
    repaired_d = 1'b0;
    loss_ev    = 1'b0;
    fail_limit = 1'b0;

    if (gameover_ctrl) begin
      state_d  = ST_INIT;
      combo_d  = '0;
      idx_d    = '0;
      fail_d   = '0;
      timer_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          combo_d  = '0;
          idx_d    = '0;
          fail_d   = '0;
          timer_d  = '0;
          locked_d = 1'b0;
          if (play_flag) state_d = ST_WORKING;
        end
        ST_WORKING: begin
          if (break_req) begin
            state_d  = ST_REPAIR;
            combo_d  = random_hex;
            idx_d    = '0;
            fail_d   = '0;
            timer_d  = '0;
            locked_d = 1'b0;
          end
        end
        ST_REPAIR: begin
          if (!locked_q) begin
            if (!timeout_hit) timer_d = timer_q + TW'(1);
            if (btn_submit) begin
              if (hex_combo == cur_digit) begin
                if (idx_q == 2'(COMBO_DIGITS - 1)) begin
                  state_d    = ST_WORKING;
                  repaired_d = 1'b1;
                  idx_d      = '0;
                end else begin
                  idx_d = idx_q + 2'd1;
                end
              end else begin
                idx_d      = '0;
                fail_d     = fail_q + 4'd1;
                fail_limit = (fail_d == 4'(MAX_FAILS));
              end
            end
            // A successful final digit beats a simultaneous timeout.
            if (!repaired_d && (timeout_hit || fail_limit)) begin
              loss_ev  = 1'b1;
              locked_d = 1'b1;
            end
          end
        end
        default: begin
          state_d  = ST_INIT;
          combo_d  = '0;
          idx_d    = '0;
          fail_d   = '0;
          timer_d  = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_INIT;
      combo_q    <= '0;
      idx_q      <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
      locked_q   <= 1'b0;
      repaired_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      combo_q    <= combo_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      locked_q   <= locked_d;
      repaired_q <= repaired_d;
    end
  end

  assign q_init    = (state_q == ST_INIT);
  assign q_working = (state_q == ST_WORKING);
  assign q_repair  = (state_q == ST_REPAIR);
  assign broken    = (state_q == ST_REPAIR);
  assign combo     = combo_q;
  assign digit_idx = idx_q;
  assign fail_cnt  = fail_q;
  assign repaired  = repaired_q;

endmodule

// File: rtl/nexys_starship_repair_bank.sv
// Bank of NUM_CH repairable sections; packs per-channel outputs and
// registers the OR of all channel loss events into one ship_lost pulse.
module nexys_starship_repair_bank
  import nexys_starship_repair_bank_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int COMBO_DIGITS   = 2,
  parameter int MAX_FAILS      = 3,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             play_flag,
  input  logic                             gameover_ctrl,
  input  logic [NUM_CH-1:0]                break_req,
  input  logic [4*COMBO_DIGITS-1:0]        random_hex,
  input  logic [3:0]                       hex_combo,
  input  logic [NUM_CH-1:0]                btn_submit,
  output logic [NUM_CH-1:0]                q_init,
  output logic [NUM_CH-1:0]                q_working,
  output logic [NUM_CH-1:0]                q_repair,
  output logic [NUM_CH-1:0]                broken,
  output logic [NUM_CH*4*COMBO_DIGITS-1:0] combo_flat,
  output logic [NUM_CH*2-1:0]              digit_idx,
  output logic [NUM_CH*4-1:0]              fail_cnt,
  output logic [NUM_CH-1:0]                repaired,
  output logic                             ship_lost
);

  localparam int CW = 4 * COMBO_DIGITS;

  logic [NUM_CH-1:0] loss_ev;
  logic              ship_lost_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nexys_starship_repair_ch #(
      .COMBO_DIGITS  (COMBO_DIGITS),
      .MAX_FAILS     (MAX_FAILS),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .Clk          (Clk),
      .Reset        (Reset),
      .play_flag    (play_flag),
      .gameover_ctrl(gameover_ctrl),
      .break_req    (break_req[g]),
      .random_hex   (random_hex),
      .hex_combo    (hex_combo),
      .btn_submit   (btn_submit[g]),
      .q_init       (q_init[g]),
      .q_working    (q_working[g]),
      .q_repair     (q_repair[g]),
      .broken       (broken[g]),
      .combo        (combo_flat[g*CW +: CW]),
      .digit_idx    (digit_idx[g*2 +: 2]),
      .fail_cnt     (fail_cnt[g*4 +: 4]),
      .repaired     (repaired[g]),
      .loss_ev      (loss_ev[g])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset || gameover_ctrl) ship_lost_q <= 1'b0;
    else                        ship_lost_q <= |loss_ev;
  end

  assign ship_lost = ship_lost_q;

endmodule

// File: tb/tb_nexys_starship_repair_bank.sv
// Randomised and directed bench for nexys_starship_repair_bank with a
// behavioural per-section model checked after every clock edge.
module tb_nexys_starship_repair_bank;

  localparam int N  = 4;
  localparam int CD = 2;
  localparam int MF = 3;
  localparam int TO = 16;
  localparam int CW = 4 * CD;

  logic              Clk = 1'b0;
  logic              Reset, play_flag, gameover_ctrl;
  logic [N-1:0]      break_req, btn_submit;
  logic [CW-1:0]     random_hex;
  logic [3:0]        hex_combo;
  logic [N-1:0]      q_init, q_working, q_repair, broken, repaired;
  logic [N*CW-1:0]   combo_flat;
  logic [N*2-1:0]    digit_idx;
  logic [N*4-1:0]    fail_cnt;
  logic              ship_lost;

  nexys_starship_repair_bank #(
    .NUM_CH(N), .COMBO_DIGITS(CD), .MAX_FAILS(MF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .gameover_ctrl(gameover_ctrl),
    .break_req(break_req), .random_hex(random_hex), .hex_combo(hex_combo),
    .btn_submit(btn_submit), .q_init(q_init), .q_working(q_working),
    .q_repair(q_repair), .broken(broken), .combo_flat(combo_flat),
    .digit_idx(digit_idx), .fail_cnt(fail_cnt), .repaired(repaired),
    .ship_lost(ship_lost)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Model: 0 = init, 1 = working, 2 = repair; age = cycles spent in repair.
  int m_st[N], m_combo[N], m_idx[N], m_fail[N], m_age[N];
  bit m_locked[N], m_rep[N];
  bit m_lost;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit lost;
    lost = 0;
    for (int i = 0; i < N; i++) begin
      m_rep[i] = 0;
      if (Reset || gameover_ctrl || m_st[i] == 0) begin
        if (m_st[i] == 0 && !Reset && !gameover_ctrl && play_flag) m_st[i] = 1;
        else if (Reset || gameover_ctrl) m_st[i] = 0;
        m_combo[i] = 0; m_idx[i] = 0; m_fail[i] = 0; m_age[i] = 0; m_locked[i] = 0;
      end else if (m_st[i] == 1) begin
        if (break_req[i]) begin
          m_st[i] = 2; m_combo[i] = int'(random_hex); m_idx[i] = 0;
          m_fail[i] = 0; m_age[i] = 0; m_locked[i] = 0;
        end
      end else if (!m_locked[i]) begin
        bit fixed, failout;
        fixed = 0; failout = 0;
        if (btn_submit[i]) begin
          if (int'(hex_combo) == ((m_combo[i] >> (4 * m_idx[i])) & 15)) begin
            if (m_idx[i] == CD - 1) fixed = 1;
            else m_idx[i]++;
          end else begin
            m_idx[i] = 0;
            m_fail[i]++;
            if (m_fail[i] == MF) failout = 1;
          end
        end
        if (fixed) begin
          m_st[i] = 1; m_rep[i] = 1; m_idx[i] = 0;
        end else if (m_age[i] == TO - 1 || failout) begin
          m_locked[i] = 1; lost = 1;
        end else begin
          m_age[i]++;
        end
      end
    end
    m_lost = Reset ? 1'b0 : lost;
  endtask

  task automatic compare_all();
    logic [N-1:0]    e_init, e_work, e_rep, e_repd;
    logic [N*CW-1:0] e_combo;
    logic [N*2-1:0]  e_idx;
    logic [N*4-1:0]  e_fail;
    for (int i = 0; i < N; i++) begin
      e_init[i] = (m_st[i] == 0);
      e_work[i] = (m_st[i] == 1);
      e_rep[i]  = (m_st[i] == 2);
      e_repd[i] = m_rep[i];
      e_combo[i*CW +: CW] = CW'(m_combo[i]);
      e_idx[i*2 +: 2]     = 2'(m_idx[i]);
      e_fail[i*4 +: 4]    = 4'(m_fail[i]);
    end
    check("q_init", 64'(q_init), 64'(e_init));
    check("q_working", 64'(q_working), 64'(e_work));
    check("q_repair", 64'(q_repair), 64'(e_rep));
    check("broken", 64'(broken), 64'(e_rep));
    check("combo_flat", 64'(combo_flat), 64'(e_combo));
    check("digit_idx", 64'(digit_idx), 64'(e_idx));
    check("fail_cnt", 64'(fail_cnt), 64'(e_fail));
    check("repaired", 64'(repaired), 64'(e_repd));
    check("ship_lost", 64'(ship_lost), 64'(m_lost));
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    Reset = 0; play_flag = 0; gameover_ctrl = 0;
    break_req = '0; btn_submit = '0; random_hex = '0; hex_combo = '0;
  endtask

  task automatic submit(input int ch, input logic [3:0] hx);
    btn_submit = '0; btn_submit[ch] = 1'b1; hex_combo = hx;
    cycle();
    btn_submit = '0;
  endtask

  task automatic brk(input logic [N-1:0] b, input logic [CW-1:0] rh);
    break_req = b; random_hex = rh;
    cycle();
    break_req = '0;
  endtask

  initial begin
    int k, hit;
    idle();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_combo[i] = 0; m_idx[i] = 0; m_fail[i] = 0;
      m_age[i] = 0; m_locked[i] = 0; m_rep[i] = 0;
    end
    m_lost = 0;
    @(negedge Clk);
    Reset = 1; cycle(); cycle(); Reset = 0;
    check("rst_init_lit", 64'(q_init), 64'hF);

    play_flag = 1; cycle(); play_flag = 0;
    check("play_lit", 64'(q_working), 64'hF);

    // Ch2 combo 3C, entered C then 3
    brk(4'b0100, 8'h3C);
    check("ch2_combo_lit", 64'(combo_flat[23:16]), 64'h3C);
    submit(2, 4'hC);
    submit(2, 4'h3);
    check("ch2_rep_lit", 64'(repaired), 64'b0100);
    cycle();
    check("ch2_rep_once_lit", 64'(repaired), 64'h0);
    check("ch2_back_lit", 64'(q_working), 64'hF);

    // Ch0 combo A5: wrong entries to lock
    brk(4'b0001, 8'hA5);
    submit(0, 4'h5);
    submit(0, 4'h0);
    check("ch0_fail1_lit", 64'(fail_cnt[3:0]), 64'h1);
    check("ch0_idx0_lit", 64'(digit_idx[1:0]), 64'h0);
    submit(0, 4'h0);
    submit(0, 4'h0);
    check("ch0_lost_lit", 64'(ship_lost), 64'h1);
    cycle();
    check("ch0_lost_once_lit", 64'(ship_lost), 64'h0);
    submit(0, 4'h5);
    check("ch0_locked_lit", 64'(digit_idx[1:0]), 64'h0);
    check("ch0_sat_lit", 64'(fail_cnt[3:0]), 64'h3);

    // Reset mid-entry
    Reset = 1; cycle(); Reset = 0;
    play_flag = 1; cycle(); play_flag = 0;
    brk(4'b0010, 8'h42);
    submit(1, 4'h2);
    check("ch1_idx1_lit", 64'(digit_idx[3:2]), 64'h1);
    Reset = 1; cycle(); Reset = 0;
    check("rst_mid_init_lit", 64'(q_init), 64'hF);
    check("rst_mid_combo_lit", 64'(combo_flat), 64'h0);
    check("rst_mid_broken_lit", 64'(broken), 64'h0);
    play_flag = 1; cycle(); play_flag = 0;

    // Timeout: loss exactly TO cycles after entering repair
    brk(4'b0010, 8'h96);
    hit = -1;
    for (k = 1; k <= 40; k++) begin
      cycle();
      if (ship_lost === 1'b1) begin hit = k; break; end
    end
    check("timeout_lat_lit", 64'(hit), 64'(TO));
    gameover_ctrl = 1; cycle(); gameover_ctrl = 0;
    play_flag = 1; cycle(); play_flag = 0;

    // Final digit in the timeout cycle wins
    brk(4'b0010, 8'h96);
    for (k = 1; k <= TO; k++) begin
      if (k == 5)  begin btn_submit = 4'b0010; hex_combo = 4'h6; end
      if (k == TO) begin btn_submit = 4'b0010; hex_combo = 4'h9; end
      cycle();
      btn_submit = '0;
    end
    check("race_rep_lit", 64'(repaired), 64'b0010);
    check("race_nolost_lit", 64'(ship_lost), 64'h0);
    cycle();

    // All channels break together; second break ignored
    brk(4'b1111, 8'h7E);
    check("all_combo_lit", 64'(combo_flat), 64'h7E7E7E7E);
    brk(4'b1111, 8'h11);
    check("all_keep_lit", 64'(combo_flat), 64'h7E7E7E7E);
    submit(1, 4'hE);
    submit(1, 4'h7);
    submit(3, 4'h0);
    submit(3, 4'h0);
    submit(3, 4'h0);
    gameover_ctrl = 1; cycle(); gameover_ctrl = 0;
    check("go_init_lit", 64'(q_init), 64'hF);
    play_flag = 1; cycle(); play_flag = 0;
    check("go_play_lit", 64'(q_working), 64'hF);

    // Random phase
    for (int n = 0; n < 4000; n++) begin
      int c;
      Reset         = ($urandom_range(0, 499) == 0);
      gameover_ctrl = ($urandom_range(0, 199) == 0);
      play_flag     = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        break_req[i]  = ($urandom_range(0, 15) == 0);
        btn_submit[i] = ($urandom_range(0, 3) == 0);
      end
      random_hex = CW'($urandom);
      c = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) hex_combo = 4'((m_combo[c] >> (4 * m_idx[c])) & 15);
      else                           hex_combo = 4'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
